// File: rtl/iir_product_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iir_product_accumulator_pkg
// Brief    : Fixed-point widths, product word layout, FSM encoding and
//            sign-magnitude <-> two's-complement helpers shared with the multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package iir_product_accumulator_pkg;

    localparam int INT_W  = 15;
    localparam int FRAC_W = 16;
    localparam int MAG_W  = INT_W + FRAC_W;   // 31-bit magnitude
    localparam int PROD_W = MAG_W + 1;        // sign + magnitude

    typedef struct packed {
        logic              sign;
        logic [INT_W-1:0]  int_part;
        logic [FRAC_W-1:0] frac;
    } prod_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Negating a zero magnitude yields zero, so -0 collapses to 0.
    function automatic logic signed [MAG_W:0] sm_to_twos32(input prod_word_t w);
        logic [MAG_W:0] mag;
        mag = {1'b0, w.int_part, w.frac};
        if (w.sign) begin
            return $signed(-mag);
        end
        return $signed(mag);
    endfunction

    // The single unrepresentable value (most negative) clamps to full-scale magnitude.
    function automatic prod_word_t twos32_to_sm(input logic signed [MAG_W:0] v);
        prod_word_t     r;
        logic [MAG_W:0] mag;
        mag = v[MAG_W] ? $unsigned(-v) : $unsigned(v);
        r.sign = v[MAG_W];
        if (mag[MAG_W]) begin
            r.int_part = '1;
            r.frac     = '1;
        end else begin
            r.int_part = mag[MAG_W-1:FRAC_W];
            r.frac     = mag[FRAC_W-1:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iir_product_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : iir_product_accumulator_if
// Brief    : Product input stream and finished-sample output stream.
// Revision : 1.0 - initial release
// ============================================================================
interface iir_product_accumulator_if;
    import iir_product_accumulator_pkg::*;

    logic              prod_valid;
    logic [PROD_W-1:0] prod_data;
    logic              prod_ready;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [INT_W-1:0]  out_int;
    logic [FRAC_W-1:0] out_frac;
    logic              sat_flag;

    // Environment side: multiplier feeding products, consumer taking samples.
    modport master (
        output prod_valid, prod_data, out_ready,
        input  prod_ready, out_valid, out_sign, out_int, out_frac, sat_flag
    );

    // Accumulator side.
    modport slave (
        input  prod_valid, prod_data, out_ready,
        output prod_ready, out_valid, out_sign, out_int, out_frac, sat_flag
    );

endinterface
`default_nettype wire

// File: rtl/iir_product_accumulator_sm_to_twos.sv
`default_nettype none
// ============================================================================
// Module   : sm_to_twos
// Brief    : Sign-magnitude product word to sign-extended two's complement.
// Revision : 1.0 - initial release
// ============================================================================
module sm_to_twos
    import iir_product_accumulator_pkg::*;
#(
    parameter int OUT_W = 36
) (
    input  prod_word_t               i_word,
    output logic signed [OUT_W-1:0]  o_value
);

    logic signed [MAG_W:0] w_tc;

    assign w_tc = sm_to_twos32(i_word);

    generate
        if (OUT_W > MAG_W + 1) begin : g_extend
            assign o_value = {{(OUT_W-MAG_W-1){w_tc[MAG_W]}}, w_tc};
        end else if (OUT_W == MAG_W + 1) begin : g_same
            assign o_value = w_tc;
        end else begin : g_bad_width
            $error("sm_to_twos: OUT_W must be at least %0d", MAG_W + 1);
            assign o_value = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/iir_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : iir_product_accumulator
// Brief    : Sums NTAPS sign-magnitude products per output sample with guard
//            bits, saturating the result back to sign-magnitude.
// Revision : 1.0 - initial release
// ============================================================================
module iir_product_accumulator
    import iir_product_accumulator_pkg::*;
#(
    parameter int NTAPS = 5,
    parameter int GUARD = 4
) (
    input  wire                       clk,
    input  wire                       rst,
    iir_product_accumulator_if.slave  bus
);

    localparam int ACC_W = MAG_W + GUARD + 1;
    localparam int CNT_W = $clog2(NTAPS + 1);

    generate
        if (NTAPS < 1 || NTAPS > (2 ** GUARD)) begin : g_bad_ntaps
            $error("iir_product_accumulator: NTAPS=%0d exceeds 2**GUARD=%0d", NTAPS, 2 ** GUARD);
        end
    endgenerate

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]   count_q, count_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_sign_q, out_sign_d;
    logic        [INT_W-1:0]   out_int_q, out_int_d;
    logic        [FRAC_W-1:0]  out_frac_q, out_frac_d;
    logic                      sat_q, sat_d;

    prod_word_t                w_word;
    logic signed [ACC_W-1:0]   w_prod_tc;
    logic signed [ACC_W-1:0]   w_base;
    logic signed [ACC_W-1:0]   w_sum;
    logic        [ACC_W-1:0]   w_mag;
    logic                      w_neg;
    logic                      w_sat;
    logic        [CNT_W-1:0]   w_cnt_inc;
    logic                      w_prod_ready;
    logic                      w_xfer;
    logic                      w_load;

    assign w_word = prod_word_t'(bus.prod_data);

    sm_to_twos #(
        .OUT_W (ACC_W)
    ) u_sm_to_twos (
        .i_word  (w_word),
        .o_value (w_prod_tc)
    );

    assign w_prod_ready = !rst && (state_q != ST_HOLD);
    assign w_xfer       = bus.prod_valid && w_prod_ready;

    // The first product of a sample loads rather than adds, so a stale
    // accumulator can never leak into a new sample.
    assign w_base    = (state_q == ST_IDLE) ? '0 : acc_q;
    assign w_sum     = w_base + w_prod_tc;
    assign w_cnt_inc = (state_q == ST_IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
    assign w_load    = w_xfer && (w_cnt_inc == CNT_W'(NTAPS));

    assign w_neg = w_sum[ACC_W-1];
    assign w_mag = w_neg ? -w_sum : w_sum;
    assign w_sat = |w_mag[ACC_W-1:MAG_W];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_int_d   = out_int_q;
        out_frac_d  = out_frac_q;
        sat_d       = sat_q;

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (w_xfer) begin
                    acc_d   = w_sum;
                    count_d = w_cnt_inc;
                    state_d = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    count_d     = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                acc_d       = '0;
                count_d     = '0;
            end
        endcase

        // Final product of the sample: register the converted result.
        if (w_load) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            out_sign_d  = w_neg;
            sat_d       = w_sat;
            out_int_d   = w_sat ? '1 : w_mag[MAG_W-1:FRAC_W];
            out_frac_d  = w_sat ? '1 : w_mag[FRAC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_int_q   <= '0;
            out_frac_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_int_q   <= out_int_d;
            out_frac_q  <= out_frac_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.prod_ready = w_prod_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sign   = out_sign_q;
    assign bus.out_int    = out_int_q;
    assign bus.out_frac   = out_frac_q;
    assign bus.sat_flag   = sat_q;

endmodule
`default_nettype wire
